fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/stream_skid_buf.sv | 69 ++++++
 rtl/fifo_stream_reader.sv | 88 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared types and constants for the FIFO stream reader     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package fifo_pkg;

  localparam int c_idx_w = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e occ);
    return logic'(occ == ONE) ? 2'd1 : ((occ == TWO) ? 2'd2 : 2'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_skid_buf : 2-entry in-order output buffer (head/tail)         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output occ_e             occ_o
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  occ_e             r_occ;
  logic             w_pop;

  assign w_pop = pop_i && (r_occ != EMPTY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_occ  <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_occ)
        EMPTY: begin
          if (push_i) begin
            r_head <= push_data_i;
            r_occ  <= ONE;
          end
        end
        ONE: begin
          if (push_i && w_pop) begin
            r_head <= push_data_i;
          end else if (push_i) begin
            r_tail <= push_data_i;
            r_occ  <= TWO;
          end else if (w_pop) begin
            r_occ <= EMPTY;
          end
        end
        TWO: begin
          // The reader never issues a read at TWO, so a push here only ever pairs with a pop.
          if (w_pop) begin
            r_head <= r_tail;
            if (push_i) r_tail <= push_data_i;
            else        r_occ  <= ONE;
          end
        end
        default: r_occ <= EMPTY;
      endcase
    end
  end

  assign data_o  = r_head;
  assign valid_o = (r_occ != EMPTY);
  assign occ_o   = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_stream_reader : FIFO-to-stream bridge with packet SOP/EOP       |
// | Option: FIFO_STREAM_READER_STATS_EN adds pkt_cnt_o                   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PKT_LEN = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_rd_req_o,
  output logic [WIDTH-1:0] src_data_o,
  output logic             src_valid_o,
  input  logic             src_ready_i,
  output logic             src_sop_o,
`ifdef FIFO_STREAM_READER_STATS_EN
  output logic [15:0]      pkt_cnt_o,
`endif
  output logic             src_eop_o
);

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PKT_LEN - 1);

  occ_e               w_occ;
  logic               w_pop;
  logic               w_rd_req;
  logic [2:0]         w_load;
  logic               r_inflight;
  logic               r_armed;
  logic [c_idx_w-1:0] r_idx;

  stream_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (r_inflight),
    .push_data_i (fifo_data_i),
    .pop_i       (src_ready_i),
    .data_o      (src_data_o),
    .valid_o     (src_valid_o),
    .occ_o       (w_occ)
  );

  assign w_pop = src_valid_o && src_ready_i;

  // Crediting this cycle's pop keeps one word per cycle across the 2-cycle read latency.
  assign w_load   = 3'(occ_count(w_occ)) + 3'(r_inflight) - 3'(w_pop);
  assign w_rd_req = r_armed && !fifo_empty_i && (w_occ != TWO) && (w_load < 3'd2);

  assign fifo_rd_req_o = w_rd_req;
  assign src_sop_o     = src_valid_o && (r_idx == '0);
  assign src_eop_o     = src_valid_o && (r_idx == c_last_idx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_armed    <= 1'b0;
      r_inflight <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_armed    <= 1'b1;
      r_inflight <= w_rd_req;
      if (w_pop) begin
        if (r_idx == c_last_idx) r_idx <= '0;
        else                     r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_pkt_cnt <= '0;
    else if (w_pop && src_eop_o) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

  assign pkt_cnt_o = r_pkt_cnt;
`endif

endmodule
`default_nettype wire
